// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and pipeline_hazard_ctrl.
// Register index width comes from `REG_LENGTH (defaults to 5).
`ifndef REG_LENGTH
`define REG_LENGTH 5
`endif

interface pipeline_hazard_ctrl_if;
  logic                   id_valid;
  logic [`REG_LENGTH-1:0] id_src1;
  logic [`REG_LENGTH-1:0] id_src2;
  logic                   id_two_src;
  logic [`REG_LENGTH-1:0] exe_src1;
  logic [`REG_LENGTH-1:0] exe_src2;
  logic [`REG_LENGTH-1:0] exe_dest;
  logic                   exe_wb_en;
  logic                   exe_mem_read;
  logic                   exe_br_taken;
  logic [`REG_LENGTH-1:0] mem_dest;
  logic                   mem_wb_en;
  logic                   mem_req;
  logic                   mem_ready;
  logic [`REG_LENGTH-1:0] wb_dest;
  logic                   wb_wb_en;
  logic                   pc_freeze;
  logic                   if_id_freeze;
  logic                   if_id_flush;
  logic                   id_exe_freeze;
  logic                   id_exe_flush;
  logic                   exe_mem_freeze;
  logic                   mem_wb_flush;
  logic [1:0]             fwd_sel1;
  logic [1:0]             fwd_sel2;
  logic                   mem_timeout;
  logic [15:0]            stall_cycles;
  logic [15:0]            flush_count;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, exe_src1, exe_src2, exe_dest,
           exe_wb_en, exe_mem_read, exe_br_taken, mem_dest, mem_wb_en, mem_req,
           mem_ready, wb_dest, wb_wb_en,
    input  pc_freeze, if_id_freeze, if_id_flush, id_exe_freeze, id_exe_flush,
           exe_mem_freeze, mem_wb_flush, fwd_sel1, fwd_sel2, mem_timeout,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, exe_src1, exe_src2, exe_dest,
           exe_wb_en, exe_mem_read, exe_br_taken, mem_dest, mem_wb_en, mem_req,
           mem_ready, wb_dest, wb_wb_en,
    output pc_freeze, if_id_freeze, if_id_flush, id_exe_freeze, id_exe_flush,
           exe_mem_freeze, mem_wb_flush, fwd_sel1, fwd_sel2, mem_timeout,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard/stall/flush controller with data-memory wait timeout.
// Optional feature macro HAZARD_FORWARDING_EN: operand forwarding, load-use-only stalls.
`ifndef REG_LENGTH
`define REG_LENGTH 5
`endif

module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, TIMEOUT = 2'd2} state_t;

  // Last wait-count value before the wait that completes the timeout budget.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 32'd1);
  localparam logic [`REG_LENGTH-1:0] REG_ZERO = {`REG_LENGTH{1'b0}};

  function automatic logic src_hit(input logic [`REG_LENGTH-1:0] dest,
                                   input logic [`REG_LENGTH-1:0] s1,
                                   input logic [`REG_LENGTH-1:0] s2,
                                   input logic two_src);
    return (dest != REG_ZERO) && ((dest == s1) || (two_src && (dest == s2)));
  endfunction

  function automatic logic [1:0] fwd_pick(input logic [`REG_LENGTH-1:0] src,
                                          input logic [`REG_LENGTH-1:0] mdest,
                                          input logic men,
                                          input logic [`REG_LENGTH-1:0] wdest,
                                          input logic wen);
    if (men && (mdest != REG_ZERO) && (mdest == src))      return 2'd1;
    else if (wen && (wdest != REG_ZERO) && (wdest == src)) return 2'd2;
    else                                                   return 2'd0;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] wait_cnt_r, wait_cnt_nxt_s;
  logic        timeout_set_s;
  logic        mem_timeout_r;
  logic [15:0] stall_cycles_r, flush_count_r;
  logic        hazard_s, mem_stall_s;
  logic [1:0]  fwd1_s, fwd2_s;
  logic pc_freeze_s, if_id_freeze_s, if_id_flush_s, id_exe_freeze_s;
  logic id_exe_flush_s, exe_mem_freeze_s, mem_wb_flush_s;

`ifdef HAZARD_FORWARDING_EN
  assign hazard_s = hz.id_valid && hz.exe_mem_read && hz.exe_wb_en &&
                    src_hit(hz.exe_dest, hz.id_src1, hz.id_src2, hz.id_two_src);
  assign fwd1_s = fwd_pick(hz.exe_src1, hz.mem_dest, hz.mem_wb_en, hz.wb_dest, hz.wb_wb_en);
  assign fwd2_s = fwd_pick(hz.exe_src2, hz.mem_dest, hz.mem_wb_en, hz.wb_dest, hz.wb_wb_en);
`else
  // Without forwarding any pending producer in EXE or MEM blocks the ID instruction.
  assign hazard_s = hz.id_valid &&
                    ((hz.exe_wb_en && src_hit(hz.exe_dest, hz.id_src1, hz.id_src2, hz.id_two_src)) ||
                     (hz.mem_wb_en && src_hit(hz.mem_dest, hz.id_src1, hz.id_src2, hz.id_two_src)));
  assign fwd1_s = 2'd0;
  assign fwd2_s = 2'd0;
  logic unused_fwd_s;
  assign unused_fwd_s = ^{hz.exe_src1, hz.exe_src2, hz.exe_mem_read, hz.wb_dest, hz.wb_wb_en};
`endif

  assign mem_stall_s = (hz.mem_req && !hz.mem_ready) || (state_r == TIMEOUT);

  // Next-state and wait-counter logic for the memory-wait FSM.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    timeout_set_s  = 1'b0;
    case (state_r)
      RUN: begin
        wait_cnt_nxt_s = 16'd0;
        if (hz.mem_req && !hz.mem_ready) state_nxt_s = MEM_WAIT;
        else                             state_nxt_s = RUN;
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = 16'd0;
        end else if (wait_cnt_r >= WAIT_LAST) begin
          state_nxt_s    = TIMEOUT;
          wait_cnt_nxt_s = wait_cnt_r + 16'd1;
          timeout_set_s  = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + 16'd1;
        end
      end
      TIMEOUT: state_nxt_s = TIMEOUT;
      default: begin
        state_nxt_s    = RUN;
        wait_cnt_nxt_s = 16'd0;
      end
    endcase
  end

  // State, wait counter, sticky timeout and saturating statistics registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= RUN;
      wait_cnt_r     <= 16'd0;
      mem_timeout_r  <= 1'b0;
      stall_cycles_r <= 16'd0;
      flush_count_r  <= 16'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      if (timeout_set_s) mem_timeout_r <= 1'b1;
      else               mem_timeout_r <= mem_timeout_r;
      if (pc_freeze_s && (stall_cycles_r != 16'hFFFF)) stall_cycles_r <= stall_cycles_r + 16'd1;
      else                                             stall_cycles_r <= stall_cycles_r;
      if (if_id_flush_s && (flush_count_r != 16'hFFFF)) flush_count_r <= flush_count_r + 16'd1;
      else                                              flush_count_r <= flush_count_r;
    end
  end

  // Freeze/flush decode: memory stall beats branch flush beats data hazard.
  always_comb begin
    pc_freeze_s      = 1'b0;
    if_id_freeze_s   = 1'b0;
    if_id_flush_s    = 1'b0;
    id_exe_freeze_s  = 1'b0;
    id_exe_flush_s   = 1'b0;
    exe_mem_freeze_s = 1'b0;
    mem_wb_flush_s   = 1'b0;
    if (!reset) begin
      pc_freeze_s = 1'b0;
    end else if (mem_stall_s) begin
      pc_freeze_s      = 1'b1;
      if_id_freeze_s   = 1'b1;
      id_exe_freeze_s  = 1'b1;
      exe_mem_freeze_s = 1'b1;
      mem_wb_flush_s   = 1'b1;
    end else if (hz.exe_br_taken) begin
      if_id_flush_s  = 1'b1;
      id_exe_flush_s = 1'b1;
    end else if (hazard_s) begin
      pc_freeze_s    = 1'b1;
      if_id_freeze_s = 1'b1;
      id_exe_flush_s = 1'b1;
    end else begin
      pc_freeze_s = 1'b0;
    end
  end

  assign hz.pc_freeze      = pc_freeze_s;
  assign hz.if_id_freeze   = if_id_freeze_s;
  assign hz.if_id_flush    = if_id_flush_s;
  assign hz.id_exe_freeze  = id_exe_freeze_s;
  assign hz.id_exe_flush   = id_exe_flush_s;
  assign hz.exe_mem_freeze = exe_mem_freeze_s;
  assign hz.mem_wb_flush   = mem_wb_flush_s;
  assign hz.fwd_sel1       = reset ? fwd1_s : 2'd0;
  assign hz.fwd_sel2       = reset ? fwd2_s : 2'd0;
  assign hz.mem_timeout    = mem_timeout_r;
  assign hz.stall_cycles   = stall_cycles_r;
  assign hz.flush_count    = flush_count_r;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (TIMEOUT_CYC = 8).
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus.slave)
  );

  always #5 clk = ~clk;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_valid = 1'b0;    bus.id_src1 = '0;       bus.id_src2 = '0;
    bus.id_two_src = 1'b0;  bus.exe_src1 = '0;      bus.exe_src2 = '0;
    bus.exe_dest = '0;      bus.exe_wb_en = 1'b0;   bus.exe_mem_read = 1'b0;
    bus.exe_br_taken = 1'b0; bus.mem_dest = '0;     bus.mem_wb_en = 1'b0;
    bus.mem_req = 1'b0;     bus.mem_ready = 1'b0;   bus.wb_dest = '0;
    bus.wb_wb_en = 1'b0;
  endtask

  task automatic check_stall(input string tag);
    check({tag, "_pc_frz"}, bus.pc_freeze, 1);
    check({tag, "_ifid_frz"}, bus.if_id_freeze, 1);
    check({tag, "_idexe_frz"}, bus.id_exe_freeze, 1);
    check({tag, "_exmem_frz"}, bus.exe_mem_freeze, 1);
    check({tag, "_memwb_fl"}, bus.mem_wb_flush, 1);
    check({tag, "_ifid_fl"}, bus.if_id_flush, 0);
    check({tag, "_idexe_fl"}, bus.id_exe_flush, 0);
  endtask

  initial begin
    clear_inputs();
    // Reset: counters clear, controls forced low even with a stall request present.
    step(); step();
    check("rst_stall_cnt", bus.stall_cycles, 0);
    check("rst_flush_cnt", bus.flush_count, 0);
    check("rst_timeout", bus.mem_timeout, 0);
    bus.mem_req = 1'b1;
    bus.exe_br_taken = 1'b1;
    #1;
    check("rst_gate_pc_frz", bus.pc_freeze, 0);
    check("rst_gate_memwb_fl", bus.mem_wb_flush, 0);
    check("rst_gate_ifid_fl", bus.if_id_flush, 0);
    clear_inputs();
    step();
    reset = 1'b1;
    step();

    // Load-use hazard: one bubble, stall counter +1.
    bus.exe_mem_read = 1'b1; bus.exe_wb_en = 1'b1; bus.exe_dest = 5;
    bus.id_src1 = 5; bus.id_valid = 1'b1;
    #1;
    check("lu_pc_frz", bus.pc_freeze, 1);
    check("lu_ifid_frz", bus.if_id_freeze, 1);
    check("lu_idexe_fl", bus.id_exe_flush, 1);
    check("lu_idexe_frz", bus.id_exe_freeze, 0);
    check("lu_ifid_fl", bus.if_id_flush, 0);
    step();
    clear_inputs();
    #1;
    check("lu_released", bus.pc_freeze, 0);
    check("lu_stall_cnt", bus.stall_cycles, 1);

    // Hazard qualifiers: src2 ignored when single-source, r0 never hazards, invalid ID.
    bus.exe_mem_read = 1'b1; bus.exe_wb_en = 1'b1; bus.exe_dest = 6;
    bus.id_src2 = 6; bus.id_valid = 1'b1; bus.id_two_src = 1'b0;
    #1; check("lu_one_src", bus.pc_freeze, 0);
    bus.id_two_src = 1'b1;
    #1; check("lu_src2", bus.pc_freeze, 1);
    bus.exe_dest = 0; bus.id_src2 = 0;
    #1; check("lu_r0", bus.pc_freeze, 0);
    bus.exe_dest = 6; bus.id_src2 = 6; bus.id_valid = 1'b0;
    #1; check("lu_invalid", bus.pc_freeze, 0);
    clear_inputs();
    // Non-load producer in EXE: hazard only without forwarding.
    bus.exe_wb_en = 1'b1; bus.exe_dest = 4; bus.id_src1 = 4; bus.id_valid = 1'b1;
    #1; check("alu_dep", bus.pc_freeze, FWD ? 0 : 1);
    clear_inputs();
    step();

    // Forwarding select.
    bus.exe_src1 = 3; bus.exe_src2 = 3; bus.mem_dest = 3; bus.wb_dest = 3;
    bus.mem_wb_en = 1'b1; bus.wb_wb_en = 1'b1;
    #1;
    check("fwd1_mem", bus.fwd_sel1, FWD ? 1 : 0);
    check("fwd2_mem", bus.fwd_sel2, FWD ? 1 : 0);
    bus.mem_wb_en = 1'b0;
    #1; check("fwd1_wb", bus.fwd_sel1, FWD ? 2 : 0);
    bus.mem_wb_en = 1'b1; bus.mem_dest = 0; bus.wb_dest = 0; bus.exe_src1 = 0;
    #1; check("fwd1_r0", bus.fwd_sel1, 0);
    clear_inputs();
    step();

    // Memory stall over a held branch for 4 cycles, then branch flush on release.
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0; bus.exe_br_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_stall($sformatf("prio_c%0d", i + 1));
      step();
    end
    bus.mem_ready = 1'b1;
    #1;
    check("prio_ifid_fl", bus.if_id_flush, 1);
    check("prio_idexe_fl", bus.id_exe_flush, 1);
    check("prio_pc_frz", bus.pc_freeze, 0);
    check("prio_exmem_frz", bus.exe_mem_freeze, 0);
    step();
    clear_inputs();
    #1;
    check("prio_flush_cnt", bus.flush_count, 1);
    check("prio_stall_cnt", bus.stall_cycles, 5);
    check("prio_no_timeout", bus.mem_timeout, 0);

    // Branch beats a simultaneous data hazard.
    bus.exe_br_taken = 1'b1;
    bus.exe_mem_read = 1'b1; bus.exe_wb_en = 1'b1; bus.exe_dest = 9;
    bus.id_src1 = 9; bus.id_valid = 1'b1;
    #1;
    check("br_idexe_fl", bus.id_exe_flush, 1);
    check("br_ifid_fl", bus.if_id_flush, 1);
    check("br_pc_frz", bus.pc_freeze, 0);
    step();
    clear_inputs();
    #1; check("br_flush_cnt", bus.flush_count, 2);

    // MEM-stage producer with two-source consumer.
    bus.mem_dest = 7; bus.mem_wb_en = 1'b1; bus.id_src2 = 7; bus.id_two_src = 1'b1;
    bus.id_valid = 1'b1; bus.exe_src2 = 7;
    #1;
    check("mem_dep_pc_frz", bus.pc_freeze, FWD ? 0 : 1);
    check("mem_dep_fwd2", bus.fwd_sel2, FWD ? 1 : 0);
    step();
    clear_inputs();
    #1;
    check("mem_dep_one_cycle", bus.pc_freeze, 0);
    check("mem_dep_stall_cnt", bus.stall_cycles, FWD ? 5 : 6);

    // Reset in the middle of MEM_WAIT.
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    #1;
    check("rstmw_pc_frz", bus.pc_freeze, 0);
    check("rstmw_memwb_fl", bus.mem_wb_flush, 0);
    step();
    check("rstmw_stall_cnt", bus.stall_cycles, 0);
    check("rstmw_flush_cnt", bus.flush_count, 0);
    reset = 1'b1;
    clear_inputs();
    step();
    check("rstmw_run", bus.pc_freeze, 0);

    // Timeout: a fresh wait budget of 8 MEM_WAIT cycles proves the FSM restarted in RUN.
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("to_not_yet", bus.mem_timeout, 0);
    step();
    check("to_set", bus.mem_timeout, 1);
    bus.mem_ready = 1'b1;
    #1;
    check("to_frozen", bus.pc_freeze, 1);
    check("to_memwb_fl", bus.mem_wb_flush, 1);
    step();
    check("to_sticky", bus.mem_timeout, 1);
    check("to_stall_cnt", bus.stall_cycles, 10);
    clear_inputs();
    #1; check("to_hold_frz", bus.pc_freeze, 1);
    reset = 1'b0;
    #1; check("to_rst_gate", bus.pc_freeze, 0);
    step();
    check("to_rst_clear", bus.mem_timeout, 0);
    reset = 1'b1;
    step();
    check("to_rst_run", bus.pc_freeze, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, default 255, maximum consecutive memory-wait cycles before timeout (1..65535).
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-low; reset==0 at a rising edge resets all state.
REQ-004 SHALL have ports: id_valid  in  1  ID stage holds a real instruction.
REQ-005 SHALL have ports: id_src1, id_src2  in  `REG_LENGTH  ID-stage source register indices.
REQ-006 SHALL have ports: id_two_src  in  1  ID instruction reads id_src2 as a register.
REQ-007 SHALL have ports: exe_src1, exe_src2, exe_dest  in  `REG_LENGTH  ID/EXE register source/destination indices.
REQ-008 SHALL have ports: exe_wb_en, exe_mem_read, exe_br_taken  in  1  ID/EXE control outputs.
REQ-009 SHALL have ports: mem_dest  in  `REG_LENGTH; mem_wb_en, mem_req, mem_ready  in  1  EXE/MEM state and data-memory handshake.
REQ-010 SHALL have ports: wb_dest  in  `REG_LENGTH; wb_wb_en  in  1  MEM/WB state.
REQ-011 SHALL have ports: pc_freeze, if_id_freeze, if_id_flush, id_exe_freeze, id_exe_flush, exe_mem_freeze, mem_wb_flush  out  1  pipeline register controls.
REQ-012 SHALL have ports: fwd_sel1, fwd_sel2  out  2  EXE operand select: 0 register file, 1 EXE/MEM result, 2 MEM/WB result.
REQ-013 SHALL have ports: mem_timeout  out  1  sticky timeout flag; stall_cycles, flush_count  out  16  saturating counters.

Function
REQ-014 SHALL implement states RUN, MEM_WAIT, TIMEOUT; RUN->MEM_WAIT when mem_req & !mem_ready; MEM_WAIT->RUN when mem_ready; MEM_WAIT->TIMEOUT when wait counter reaches TIMEOUT_CYC with mem_ready low; TIMEOUT exits only by reset.
REQ-015 SHALL, whenever mem_req & !mem_ready (any state) or in TIMEOUT, assert pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze and mem_wb_flush, and deassert all other flush outputs.
REQ-016 SHALL, with no memory stall and exe_br_taken=1, assert if_id_flush and id_exe_flush in the same cycle (zero latency), no freezes.
REQ-017 SHALL detect load-use: id_valid & exe_mem_read & exe_wb_en & exe_dest!=0 & (exe_dest==id_src1 | id_two_src & exe_dest==id_src2).
REQ-018 SHALL, on hazard with no memory stall and no branch, assert pc_freeze, if_id_freeze, id_exe_flush (one bubble per hazard cycle).
REQ-019 SHALL apply priority: memory stall > branch flush > data hazard; a branch held in EXE during a memory stall is flushed on the first unfrozen cycle.
REQ-020 SHALL compute fwd_selN: 1 if mem_wb_en & mem_dest!=0 & mem_dest==exe_srcN; else 2 if wb_wb_en & wb_dest!=0 & wb_dest==exe_srcN; else 0 (EXE/MEM wins).
REQ-021 SHALL count MEM_WAIT cycles in a 16-bit wait counter, cleared on every RUN entry.
REQ-022 SHALL increment stall_cycles each cycle pc_freeze=1 and flush_count each cycle if_id_flush=1, both saturating at 16'hFFFF.
REQ-023 SHALL set mem_timeout on TIMEOUT entry and hold it until reset.

Reset
REQ-024 SHALL, on reset==0 at a rising edge, load state RUN, wait counter 0, mem_timeout 0, stall_cycles 0, flush_count 0.
REQ-025 SHALL force all freeze/flush outputs and fwd_sel1/2 to 0 while reset==0, including reset asserted mid-MEM_WAIT or mid-TIMEOUT.

Configuration
REQ-026 SHALL use macro HAZARD_FORWARDING_EN; defined: forwarding per REQ-020, only load-use stalls per REQ-017.
REQ-027 SHALL, without HAZARD_FORWARDING_EN, tie fwd_sel1/2 to 0 and extend the hazard to any id_src match (per REQ-017 operand rule, dest!=0) against exe_dest with exe_wb_en or mem_dest with mem_wb_en.

Verification
REQ-028 SHALL test load-use: exe_mem_read=1, exe_wb_en=1, exe_dest=5, id_src1=5, id_valid=1 -> pc_freeze=1, if_id_freeze=1, id_exe_flush=1 one cycle; stall_cycles=1.
REQ-029 SHALL test forwarding: exe_src1=3, mem_dest=3, wb_dest=3, both wb_en=1 -> fwd_sel1=1; mem_wb_en=0 -> fwd_sel1=2; dest=0 -> fwd_sel1=0.
REQ-030 SHALL test priority: mem_req=1, mem_ready=0 for 4 cycles with exe_br_taken=1 -> full freeze, no flush; cycle 5 mem_ready=1 -> if_id_flush=1, id_exe_flush=1, flush_count=1.
REQ-031 SHALL test timeout with TIMEOUT_CYC=8: mem_ready held 0 -> mem_timeout=1 after 8 MEM_WAIT cycles, stays 1 after mem_ready=1 until reset=0.
REQ-032 SHALL test reset mid-MEM_WAIT: reset=0 one edge -> all outputs 0, counters 0, state RUN.
REQ-033 SHALL test without HAZARD_FORWARDING_EN: mem_dest=7, mem_wb_en=1, id_src2=7, id_two_src=1 -> one-cycle stall, fwd_sel2=0.
